datapath_seq: RTL and testbench
===============================

# datapath_seq

Parametrised, self-sequencing successor to the lab datapath. It has a register file of 2^AW registers of W bits, operand registers A and B, a shifter, an ALU, result register C, Z/N/V status and a four-way writeback mux. It also has a built-in multi-cycle sequencer, so the caller issues one command per start pulse instead of stepping the load, execute and write enables by hand. It sits between the future instruction decoder/controller and memory. Its outputs feed the PC and memory-address logic.

## Interface
- W, 16, data width (≥4).
- AW, 3, register address width; register count is 2^AW.
- PCW, 8, PC width (≤W); the PC is zero-extended to W on writeback.

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  command strobe; sampled only when busy=0
- alu_op  in  2  ALU operation: 00 add, 01 sub (A−B), 10 and, 11 not B
- shift_op  in  2  B-path shift: 00 none, 01 LSL1, 10 LSR1 (zero fill), 11 ASR1
- rn, rm, rd  in  AW  A source, B source and destination register
- sel_A  in  1  1: A operand is 0
- sel_B  in  1  1: B operand is sximm5; shifter bypassed
- wb_sel  in  2  writeback source: 00 C, 01 {0,pc}, 10 sximm8, 11 mdata
- wr  in  1  1: write the register file; 0: compare only (status and C still update)
- sximm8, sximm5, mdata  in  W  immediate and memory data
- pc  in  PCW  program counter
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse
- datapath_out  out  W  register C
- Z_out, N_out, V_out  out  1  status flags

## Operation
- All command fields are latched into a command register when start=1 and busy=0. Inputs are ignored afterwards until the next accept.
  - Exception: mdata, pc and sximm8 are sampled in the WRITE state.
- States and transitions:
  - IDLE → LOAD_A when wb_sel=00; IDLE → WRITE when wb_sel≠00 (direct move, no ALU).
  - LOAD_A: A ← R[rn]; → LOAD_B.
  - LOAD_B: B ← R[rm]; → EXEC.
  - EXEC: C ← ALU result; status ← flags; → WRITE if wr=1, else → IDLE with done.
  - WRITE: R[rd] ← writeback source if wr=1; → IDLE with done.
  - A direct move with wr=0 still passes through WRITE, performs no write, then asserts done.
- ALU arithmetic:
  - Add and sub are modulo 2^W.
  - Z = (result == 0).
  - N = result[W−1].
  - V = signed overflow for add and sub; V = 0 for and and not.
- Status and C change only in EXEC. Direct moves leave C and the flags unchanged.
- Register reads in LOAD_A/LOAD_B see all writes from earlier commands. rn=rd or rm=rd within a command reads the old value.
- A start while busy=1 is ignored and is not queued.
- Reset: the state returns to IDLE.
  - All register-file entries, A, B, C and the flags clear to 0; busy=0, done=0.
  - Reset asserted mid-command aborts it with no register write and no done.

## Timing
- Let edge n be the edge that accepts start.
  - ALU op with write: done is high in the cycle after edge n+4.
  - ALU op with wr=0: done is high after edge n+3.
  - Direct move: done is high after edge n+1.
- busy is high from edge n until the edge that raises done; it is low while done is high.
- done is registered and lasts exactly one cycle. A start in the done cycle is accepted, so commands can run back to back.
- datapath_out and the flags are registered; they change on the EXEC edge.
- R[rd] is visible to a subsequent command from its LOAD_A onward.

## Test plan
1. Assert rst mid-simulation → all outputs are 0 immediately (before the next edge) and busy=0. Read back every register via add with sel_A=1 → all 0.
2. Default parameters:
   - MOV R0 and MOV R7 with sximm8=0xF0F0, then ADD R5,R0,R7 LSL1 → datapath_out=0xD2D0, ZNV=010.
   - The ADD's done arrives 4 edges after its accept edge, with busy high throughout.
3. R1=0x7FFF, R2=0xFFFF, SUB R3,R1,R2 → 0x8000, ZNV=011. The following and R3 with sximm5=0x00FF (sel_B=1) → 0x0000, ZNV=100.
4. Compare R0−R0 with wr=0 and rd=R0 → Z=1 and done after edge n+3. A subsequent read of R0 still returns 0xF0F0.
5. Pulse start during LOAD_B with different fields → ignored and the result is unchanged. A start asserted in the done cycle → accepted on that edge.
6. Assert rst during EXEC of ADD R6 → no done and R6 stays 0. Separately, an instance with W=8, AW=2, pc=0x5A, wb_sel=01 → R[rd]=0x5A; and not B with B=0x80 under ASR1 → 0x3F, N=0.

Source files
------------

// File: rtl/datapath_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : datapath_seq_if
//  Description : Command/status bundle between a controller and datapath_seq.
//                The master drives one command per start strobe and watches
//                busy/done. The slave is the datapath itself.
//  Signals     : start, alu_op, shift_op, rn, rm, rd, sel_A, sel_B, wb_sel,
//                wr, sximm8, sximm5, mdata, pc       (master -> slave)
//                busy, done, datapath_out, Z_out, N_out, V_out (slave -> master)
//  Revision    : 1.0 - initial release
// ============================================================================
interface datapath_seq_if #(
    parameter int W   = 16,
    parameter int AW  = 3,
    parameter int PCW = 8
);
    // Command fields
    logic            start;
    logic [1:0]      alu_op;
    logic [1:0]      shift_op;
    logic [AW-1:0]   rn;
    logic [AW-1:0]   rm;
    logic [AW-1:0]   rd;
    logic            sel_A;
    logic            sel_B;
    logic [1:0]      wb_sel;
    logic            wr;
    logic [W-1:0]    sximm8;
    logic [W-1:0]    sximm5;
    logic [W-1:0]    mdata;
    logic [PCW-1:0]  pc;

    // Status / results
    logic            busy;
    logic            done;
    logic [W-1:0]    datapath_out;
    logic            Z_out;
    logic            N_out;
    logic            V_out;

    modport master (
        output start, alu_op, shift_op, rn, rm, rd, sel_A, sel_B, wb_sel, wr,
               sximm8, sximm5, mdata, pc,
        input  busy, done, datapath_out, Z_out, N_out, V_out
    );

    modport slave (
        input  start, alu_op, shift_op, rn, rm, rd, sel_A, sel_B, wb_sel, wr,
               sximm8, sximm5, mdata, pc,
        output busy, done, datapath_out, Z_out, N_out, V_out
    );
endinterface
`default_nettype wire

// File: rtl/datapath_seq.sv
`default_nettype none
// ============================================================================
//  Module      : datapath_seq
//  Description : Self-sequencing datapath. A register file of 2^AW x W,
//                operand registers A/B, a one-bit B-path shifter, a four-op
//                ALU, result register C with Z/N/V status and a four-way
//                writeback mux. One start strobe runs a complete command:
//                  ALU op : IDLE -> LOAD_A -> LOAD_B -> EXEC [-> WRITE] -> IDLE
//                  move   : IDLE -> WRITE -> IDLE
//  Ports       : clk  - rising-edge clock
//                rst  - asynchronous active-high reset
//                bus  - datapath_seq_if.slave (command in, status out)
//  Parameters  : W (data width, >=4), AW (register address width),
//                PCW (PC width, <=W; zero-extended on writeback)
//                The interface instance must carry the same W/AW/PCW.
//  Revision    : 1.0 - initial release
// ============================================================================
module datapath_seq #(
    parameter int W   = 16,
    parameter int AW  = 3,
    parameter int PCW = 8
) (
    input  wire logic       clk,
    input  wire logic       rst,
    datapath_seq_if.slave   bus
);

    localparam int c_NREG = 1 << AW;

    // ------------------------------------------------------------------
    // Sequencer state encoding
    // ------------------------------------------------------------------
    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_LOAD_A = 3'd1;
    localparam logic [2:0] c_ST_LOAD_B = 3'd2;
    localparam logic [2:0] c_ST_EXEC   = 3'd3;
    localparam logic [2:0] c_ST_WRITE  = 3'd4;

    // Operation / writeback encodings
    localparam logic [1:0] c_ALU_ADD = 2'b00;
    localparam logic [1:0] c_ALU_SUB = 2'b01;
    localparam logic [1:0] c_ALU_AND = 2'b10;
    localparam logic [1:0] c_ALU_NOT = 2'b11;

    localparam logic [1:0] c_SH_NONE = 2'b00;
    localparam logic [1:0] c_SH_LSL1 = 2'b01;
    localparam logic [1:0] c_SH_LSR1 = 2'b10;
    localparam logic [1:0] c_SH_ASR1 = 2'b11;

    localparam logic [1:0] c_WB_C     = 2'b00;
    localparam logic [1:0] c_WB_PC    = 2'b01;
    localparam logic [1:0] c_WB_IMM8  = 2'b10;
    localparam logic [1:0] c_WB_MDATA = 2'b11;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic [2:0]     r_state;
    logic [2:0]     w_state_next;

    // Sequencer control strobes (decoded from the current state)
    logic           w_cmd_load;
    logic           w_load_a;
    logic           w_load_b;
    logic           w_exec;
    logic           w_rf_we;
    logic           w_done_set;
    logic           w_busy;

    // Latched command
    logic [1:0]     r_alu_op;
    logic [1:0]     r_shift_op;
    logic [AW-1:0]  r_rn;
    logic [AW-1:0]  r_rm;
    logic [AW-1:0]  r_rd;
    logic           r_sel_a;
    logic           r_sel_b;
    logic [1:0]     r_wb_sel;
    logic           r_wr;
    logic [W-1:0]   r_sximm5;

    // Datapath storage
    logic [W-1:0]   r_regs [c_NREG];
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic [W-1:0]   r_c;
    logic           r_z;
    logic           r_n;
    logic           r_v;
    logic           r_done;

    // Datapath combinational nets
    logic [W-1:0]   w_b_shifted;
    logic [W-1:0]   w_ain;
    logic [W-1:0]   w_bin;
    logic [W-1:0]   w_alu;
    logic           w_alu_v;
    logic [W-1:0]   w_wb_data;
    logic [PCW-1:0] w_pc;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                // Non-C writeback sources skip the ALU entirely.
                if (bus.start) begin
                    if (bus.wb_sel == c_WB_C) begin
                        w_state_next = c_ST_LOAD_A;
                    end else begin
                        w_state_next = c_ST_WRITE;
                    end
                end
            end
            c_ST_LOAD_A: w_state_next = c_ST_LOAD_B;
            c_ST_LOAD_B: w_state_next = c_ST_EXEC;
            c_ST_EXEC: begin
                // A compare (wr=0) finishes here; no WRITE visit needed.
                if (r_wr) begin
                    w_state_next = c_ST_WRITE;
                end else begin
                    w_state_next = c_ST_IDLE;
                end
            end
            c_ST_WRITE:  w_state_next = c_ST_IDLE;
            default:     w_state_next = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_cmd_load = 1'b0;
        w_load_a   = 1'b0;
        w_load_b   = 1'b0;
        w_exec     = 1'b0;
        w_rf_we    = 1'b0;
        w_done_set = 1'b0;
        w_busy     = 1'b1;
        case (r_state)
            c_ST_IDLE: begin
                w_busy     = 1'b0;
                w_cmd_load = bus.start;
            end
            c_ST_LOAD_A: w_load_a = 1'b1;
            c_ST_LOAD_B: w_load_b = 1'b1;
            c_ST_EXEC: begin
                w_exec     = 1'b1;
                w_done_set = ~r_wr;
            end
            c_ST_WRITE: begin
                // A direct move with wr=0 still passes through here but
                // leaves the register file untouched.
                w_rf_we    = r_wr;
                w_done_set = 1'b1;
            end
            default: w_busy = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Command register: captured on accept, held for the whole command.
    // mdata, pc and sximm8 are deliberately not captured; they are taken
    // live in the WRITE state so memory data can arrive late.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alu_op   <= '0;
            r_shift_op <= '0;
            r_rn       <= '0;
            r_rm       <= '0;
            r_rd       <= '0;
            r_sel_a    <= 1'b0;
            r_sel_b    <= 1'b0;
            r_wb_sel   <= '0;
            r_wr       <= 1'b0;
            r_sximm5   <= '0;
        end else if (w_cmd_load) begin
            r_alu_op   <= bus.alu_op;
            r_shift_op <= bus.shift_op;
            r_rn       <= bus.rn;
            r_rm       <= bus.rm;
            r_rd       <= bus.rd;
            r_sel_a    <= bus.sel_A;
            r_sel_b    <= bus.sel_B;
            r_wb_sel   <= bus.wb_sel;
            r_wr       <= bus.wr;
            r_sximm5   <= bus.sximm5;
        end
    end

    // ------------------------------------------------------------------
    // Register file. Writes land on the WRITE edge, so the next command's
    // LOAD_A (at least one edge later) already sees the new value, and a
    // command reading its own rd sees the old value.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_rf_we) begin
            r_regs[r_rd] <= w_wb_data;
        end
    end

    // ------------------------------------------------------------------
    // Operand registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a <= '0;
            r_b <= '0;
        end else begin
            if (w_load_a) r_a <= r_regs[r_rn];
            if (w_load_b) r_b <= r_regs[r_rm];
        end
    end

    // ------------------------------------------------------------------
    // B-path shifter and operand selection
    // ------------------------------------------------------------------
    always_comb begin
        w_b_shifted = r_b;
        case (r_shift_op)
            c_SH_NONE: w_b_shifted = r_b;
            c_SH_LSL1: w_b_shifted = {r_b[W-2:0], 1'b0};
            c_SH_LSR1: w_b_shifted = {1'b0, r_b[W-1:1]};
            c_SH_ASR1: w_b_shifted = {r_b[W-1], r_b[W-1:1]};
            default:   w_b_shifted = r_b;
        endcase
    end

    // The immediate path bypasses the shifter.
    assign w_ain = r_sel_a ? '0 : r_a;
    assign w_bin = r_sel_b ? r_sximm5 : w_b_shifted;

    // ------------------------------------------------------------------
    // ALU. Overflow is only meaningful for add/sub and is forced to 0 for
    // the logical ops.
    // ------------------------------------------------------------------
    always_comb begin
        w_alu   = '0;
        w_alu_v = 1'b0;
        case (r_alu_op)
            c_ALU_ADD: begin
                w_alu   = w_ain + w_bin;
                // Same-sign operands producing an opposite-sign sum.
                w_alu_v = (w_ain[W-1] == w_bin[W-1]) && (w_alu[W-1] != w_ain[W-1]);
            end
            c_ALU_SUB: begin
                w_alu   = w_ain - w_bin;
                // Different-sign operands where the sign of A is lost.
                w_alu_v = (w_ain[W-1] != w_bin[W-1]) && (w_alu[W-1] != w_ain[W-1]);
            end
            c_ALU_AND: w_alu = w_ain & w_bin;
            c_ALU_NOT: w_alu = ~w_bin;
            default:   w_alu = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Result register and status: updated only in EXEC.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_c <= '0;
            r_z <= 1'b0;
            r_n <= 1'b0;
            r_v <= 1'b0;
        end else if (w_exec) begin
            r_c <= w_alu;
            r_z <= (w_alu == '0);
            r_n <= w_alu[W-1];
            r_v <= w_alu_v;
        end
    end

    // ------------------------------------------------------------------
    // Writeback mux
    // ------------------------------------------------------------------
    assign w_pc = bus.pc;

    always_comb begin
        w_wb_data = r_c;
        case (r_wb_sel)
            c_WB_C:     w_wb_data = r_c;
            c_WB_PC:    w_wb_data = W'(w_pc);
            c_WB_IMM8:  w_wb_data = bus.sximm8;
            c_WB_MDATA: w_wb_data = bus.mdata;
            default:    w_wb_data = r_c;
        endcase
    end

    // ------------------------------------------------------------------
    // Completion pulse: registered, so it is high for exactly the cycle
    // after the final edge of the command, while the FSM is back in IDLE.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_done_set;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.busy         = w_busy;
    assign bus.done         = r_done;
    assign bus.datapath_out = r_c;
    assign bus.Z_out        = r_z;
    assign bus.N_out        = r_n;
    assign bus.V_out        = r_v;

endmodule
`default_nettype wire

// File: tb/tb_datapath_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_datapath_seq
//  Description : Self-checking bench for datapath_seq. A table of commands
//                with expected C/flags/latency runs back to back on a
//                W=16 instance; expected results go to a scoreboard queue at
//                issue time and are popped when done pulses. Hand-written
//                sequences cover reset abort and a W=8, AW=2 instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_datapath_seq;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    datapath_seq_if #(.W(16), .AW(3), .PCW(8)) bus ();
    datapath_seq #(.W(16), .AW(3), .PCW(8)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    datapath_seq_if #(.W(8), .AW(2), .PCW(8)) bus8 ();
    datapath_seq #(.W(8), .AW(2), .PCW(8)) u_dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Command vectors
    // ------------------------------------------------------------------
    typedef struct {
        string       name;
        logic [1:0]  alu, sh;
        logic [2:0]  rn, rm, rd;
        logic        sa, sb;
        logic [1:0]  wb;
        logic        wr;
        logic [15:0] imm8, imm5, md;
        logic [7:0]  pc;
        logic [15:0] eo;     // expected datapath_out after done
        logic [2:0]  ez;     // expected {Z,N,V}
        int          lat;    // edges from accept edge to done-raising edge
        int          poke;   // cycle index at which to pulse a spurious start (-1: none)
    } vec_t;

    function automatic vec_t mk(string name, logic [1:0] alu, logic [1:0] sh,
                                logic [2:0] rn, logic [2:0] rm, logic [2:0] rd,
                                logic sa, logic sb, logic [1:0] wb, logic wr,
                                logic [15:0] imm8, logic [15:0] imm5, logic [15:0] md,
                                logic [7:0] pc, logic [15:0] eo, logic [2:0] ez,
                                int lat, int poke);
        vec_t v;
        v.name = name; v.alu = alu; v.sh = sh; v.rn = rn; v.rm = rm; v.rd = rd;
        v.sa = sa; v.sb = sb; v.wb = wb; v.wr = wr; v.imm8 = imm8; v.imm5 = imm5;
        v.md = md; v.pc = pc; v.eo = eo; v.ez = ez; v.lat = lat; v.poke = poke;
        return v;
    endfunction

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    typedef struct {
        logic [15:0] out;
        logic [2:0]  znv;
        string       name;
    } exp_t;

    exp_t sb_q[$];

    always @(negedge clk) begin
        exp_t e;
        if (bus.done === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_done: actual done=1 required done=0");
            end else begin
                e = sb_q.pop_front();
                check({e.name, "_out"}, 32'(bus.datapath_out), 32'(e.out));
                check({e.name, "_znv"}, 32'({bus.Z_out, bus.N_out, bus.V_out}), 32'(e.znv));
            end
        end
    end

    task automatic drive(input vec_t v);
        bus.alu_op   = v.alu;
        bus.shift_op = v.sh;
        bus.rn       = v.rn;
        bus.rm       = v.rm;
        bus.rd       = v.rd;
        bus.sel_A    = v.sa;
        bus.sel_B    = v.sb;
        bus.wb_sel   = v.wb;
        bus.wr       = v.wr;
        bus.sximm8   = v.imm8;
        bus.sximm5   = v.imm5;
        bus.mdata    = v.md;
        bus.pc       = v.pc;
    endtask

    // Issues a command immediately (so a call made in a done cycle is a
    // back-to-back accept) and returns #1 after the edge that raises done.
    task automatic run_vec(input vec_t v);
        int lat;
        logic busy_ok;
        exp_t e;
        e.out = v.eo; e.znv = v.ez; e.name = v.name;
        drive(v);
        bus.start = 1'b1;
        sb_q.push_back(e);
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 0;
        busy_ok = 1'b1;
        while (bus.done !== 1'b1 && lat < 20) begin
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            if (lat == v.poke) begin
                // Different latched fields; must be ignored while busy.
                bus.alu_op = ~v.alu;
                bus.rn     = 3'(v.rn + 3'd1);
                bus.rm     = 3'(v.rm + 3'd1);
                bus.sel_A  = ~v.sa;
                bus.wb_sel = 2'b10;
                bus.start  = 1'b1;
            end
            @(posedge clk); #1;
            bus.start = 1'b0;
            drive(v);
            lat++;
        end
        check({v.name, "_latency"}, 32'(lat), 32'(v.lat));
        check({v.name, "_busy_during"}, 32'(busy_ok), 32'd1);
        check({v.name, "_busy_at_done"}, 32'(bus.busy), 32'd0);
    endtask

    // W=8 instance: direct check at done.
    task automatic run8(input string name, input logic [1:0] alu, input logic [1:0] sh,
                        input logic [1:0] rm, input logic [1:0] rd, input logic sa,
                        input logic [1:0] wb, input logic wr, input logic [7:0] imm8,
                        input logic [7:0] pc, input logic [7:0] eo, input logic [2:0] ez,
                        input int elat);
        int lat;
        bus8.alu_op = alu; bus8.shift_op = sh; bus8.rn = 2'd0; bus8.rm = rm; bus8.rd = rd;
        bus8.sel_A = sa; bus8.sel_B = 1'b0; bus8.wb_sel = wb; bus8.wr = wr;
        bus8.sximm8 = imm8; bus8.pc = pc;
        bus8.start = 1'b1;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        lat = 0;
        while (bus8.done !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, "_latency"}, 32'(lat), 32'(elat));
        check({name, "_out"}, 32'(bus8.datapath_out), 32'(eo));
        check({name, "_znv"}, 32'({bus8.Z_out, bus8.N_out, bus8.V_out}), 32'(ez));
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_out"},  32'(bus.datapath_out), 32'd0);
        check({name, "_znv"},  32'({bus.Z_out, bus.N_out, bus.V_out}), 32'd0);
        check({name, "_busy"}, 32'(bus.busy), 32'd0);
        check({name, "_done"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        vec_t vecs[$];
        vec_t abort_v;

        vecs.push_back(mk("mov_r0",      2'b00, 2'b00, 3'd0, 3'd0, 3'd0, 0, 0, 2'b10, 1, 16'hF0F0, 16'h0000, 16'h0000, 8'h00, 16'h0000, 3'b000, 1, -1));
        vecs.push_back(mk("mov_r7",      2'b00, 2'b00, 3'd0, 3'd0, 3'd7, 0, 0, 2'b10, 1, 16'hF0F0, 16'h0000, 16'h0000, 8'h00, 16'h0000, 3'b000, 1, -1));
        vecs.push_back(mk("add_r5_lsl",  2'b00, 2'b01, 3'd0, 3'd7, 3'd5, 0, 0, 2'b00, 1, 16'h0000, 16'h0000, 16'h0000, 8'h00, 16'hD2D0, 3'b010, 4, -1));
        vecs.push_back(mk("mov_r1_md",   2'b00, 2'b00, 3'd0, 3'd0, 3'd1, 0, 0, 2'b11, 1, 16'h0000, 16'h0000, 16'h7FFF, 8'h00, 16'hD2D0, 3'b010, 1, -1));
        vecs.push_back(mk("mov_r2",      2'b00, 2'b00, 3'd0, 3'd0, 3'd2, 0, 0, 2'b10, 1, 16'hFFFF, 16'h0000, 16'h0000, 8'h00, 16'hD2D0, 3'b010, 1, -1));
        vecs.push_back(mk("sub_r3",      2'b01, 2'b00, 3'd1, 3'd2, 3'd3, 0, 0, 2'b00, 1, 16'h0000, 16'h0000, 16'h0000, 8'h00, 16'h8000, 3'b011, 4, -1));
        vecs.push_back(mk("and_imm",     2'b10, 2'b00, 3'd3, 3'd0, 3'd4, 0, 1, 2'b00, 1, 16'h0000, 16'h00FF, 16'h0000, 8'h00, 16'h0000, 3'b100, 4, -1));
        vecs.push_back(mk("rd_r5_poke",  2'b00, 2'b00, 3'd0, 3'd5, 3'd0, 1, 0, 2'b00, 0, 16'h0000, 16'h0000, 16'h0000, 8'h00, 16'hD2D0, 3'b010, 3, 1));
        vecs.push_back(mk("cmp_r0",      2'b01, 2'b00, 3'd0, 3'd0, 3'd0, 0, 0, 2'b00, 0, 16'h0000, 16'h0000, 16'h0000, 8'h00, 16'h0000, 3'b100, 3, -1));
        vecs.push_back(mk("rd_r0",       2'b00, 2'b00, 3'd0, 3'd0, 3'd0, 1, 0, 2'b00, 0, 16'h0000, 16'h0000, 16'h0000, 8'h00, 16'hF0F0, 3'b010, 3, -1));
        vecs.push_back(mk("mov_r6_pc",   2'b00, 2'b00, 3'd0, 3'd0, 3'd6, 0, 0, 2'b01, 1, 16'h0000, 16'h0000, 16'h0000, 8'hA5, 16'hF0F0, 3'b010, 1, -1));
        vecs.push_back(mk("rd_r6",       2'b00, 2'b00, 3'd0, 3'd6, 3'd0, 1, 0, 2'b00, 0, 16'h0000, 16'h0000, 16'h0000, 8'h00, 16'h00A5, 3'b000, 3, -1));
        vecs.push_back(mk("mov_nowr",    2'b00, 2'b00, 3'd0, 3'd0, 3'd1, 0, 0, 2'b10, 0, 16'h1234, 16'h0000, 16'h0000, 8'h00, 16'h00A5, 3'b000, 1, -1));
        vecs.push_back(mk("rd_r1",       2'b00, 2'b00, 3'd0, 3'd1, 3'd0, 1, 0, 2'b00, 0, 16'h0000, 16'h0000, 16'h0000, 8'h00, 16'h7FFF, 3'b000, 3, -1));
        vecs.push_back(mk("not_lsr_r2",  2'b11, 2'b10, 3'd0, 3'd2, 3'd0, 0, 0, 2'b00, 0, 16'h0000, 16'h0000, 16'h0000, 8'h00, 16'h8000, 3'b010, 3, -1));
        vecs.push_back(mk("asr_r3",      2'b00, 2'b11, 3'd0, 3'd3, 3'd0, 1, 0, 2'b00, 0, 16'h0000, 16'h0000, 16'h0000, 8'h00, 16'hC000, 3'b010, 3, -1));
        vecs.push_back(mk("add_r2_self", 2'b00, 2'b00, 3'd2, 3'd2, 3'd2, 0, 0, 2'b00, 1, 16'h0000, 16'h0000, 16'h0000, 8'h00, 16'hFFFE, 3'b010, 4, -1));
        vecs.push_back(mk("rd_r2",       2'b00, 2'b00, 3'd0, 3'd2, 3'd0, 1, 0, 2'b00, 0, 16'h0000, 16'h0000, 16'h0000, 8'h00, 16'hFFFE, 3'b010, 3, -1));

        abort_v = mk("abort_r6", 2'b00, 2'b00, 3'd0, 3'd7, 3'd6, 0, 0, 2'b00, 1, 16'h0000, 16'h0000, 16'h0000, 8'h00, 16'h0000, 3'b000, 4, -1);

        // Idle values on both buses
        bus.start = 1'b0;
        drive(abort_v);
        bus8.start = 1'b0; bus8.alu_op = '0; bus8.shift_op = '0; bus8.rn = '0; bus8.rm = '0;
        bus8.rd = '0; bus8.sel_A = 1'b0; bus8.sel_B = 1'b0; bus8.wb_sel = '0; bus8.wr = 1'b0;
        bus8.sximm8 = '0; bus8.sximm5 = '0; bus8.mdata = '0; bus8.pc = '0;

        // Power-on reset
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        check("por8_out",  32'(bus8.datapath_out), 32'd0);
        check("por8_busy", 32'(bus8.busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Table: commands run back to back (each issue lands in the
        // previous command's done cycle).
        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i]);
        end
        @(posedge clk); #1;

        // Reset during EXEC of ADD R6: no done, no write, outputs clear at once.
        drive(abort_v);
        bus.start = 1'b1;
        @(posedge clk); #1;                 // accept edge n -> LOAD_A
        bus.start = 1'b0;
        @(posedge clk); #1;                 // LOAD_B
        @(posedge clk); #1;                 // EXEC
        check("pre_abort_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(posedge clk);           // any done here is unexpected
        #1;
        check("post_abort_busy", 32'(bus.busy), 32'd0);

        // Every register reads back as zero.
        for (int r = 0; r < 8; r++) begin
            vec_t rv;
            rv = mk($sformatf("rb_r%0d", r), 2'b00, 2'b00, 3'd0, 3'(r), 3'd0, 1, 0, 2'b00, 0,
                    16'h0000, 16'h0000, 16'h0000, 8'h00, 16'h0000, 3'b100, 3, -1);
            run_vec(rv);
        end
        @(posedge clk); #1;

        // W=8, AW=2 instance
        run8("w8_mov_pc",  2'b00, 2'b00, 2'd0, 2'd1, 1'b0, 2'b01, 1'b1, 8'h00, 8'h5A, 8'h00, 3'b000, 1);
        run8("w8_rd_r1",   2'b00, 2'b00, 2'd1, 2'd0, 1'b1, 2'b00, 1'b0, 8'h00, 8'h00, 8'h5A, 3'b000, 3);
        run8("w8_mov_80",  2'b00, 2'b00, 2'd0, 2'd2, 1'b0, 2'b10, 1'b1, 8'h80, 8'h00, 8'h5A, 3'b000, 1);
        run8("w8_not_asr", 2'b11, 2'b11, 2'd2, 2'd3, 1'b0, 2'b00, 1'b1, 8'h00, 8'h00, 8'h3F, 3'b000, 4);

        repeat (3) @(posedge clk);
        #1;
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
